// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
//   statetype        - main FSM state enumeration
//   OP_*             - opcode field values (instr[6:0]) recognised by the decoder
//   ALUOP_*          - ALUOp encodings driven to aludec
//   RES_*            - ResultSrc encodings
//   SRCA_* / SRCB_*  - ALU operand select encodings
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } statetype;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Main control FSM of the multicycle RISC-V datapath.
// Moore decode of the state; only FETCH (IRWrite/PCUpdate) and MEMWRITE
// (instr_done) look at mem_ready, the unified memory handshake.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   op         in   [6:0] opcode of the instruction register
//   mem_ready  in   1 = current memory access completes this cycle
//   PCUpdate   out  unconditional PC write enable
//   Branch     out  conditional PC write (combined with Zero outside)
//   RegWrite   out  register file write enable
//   MemWrite   out  data memory write strobe
//   IRWrite    out  instruction register / OldPC write enable
//   AdrSrc     out  memory address select (0 = PC, 1 = Result)
//   ResultSrc  out  [1:0] result select
//   ALUSrcA    out  [1:0] ALU operand A select
//   ALUSrcB    out  [1:0] ALU operand B select
//   ALUOp      out  [1:0] operation class for aludec
//   instr_done out  one-cycle pulse when an instruction retires
//   illegal    out  one-cycle pulse for an unsupported opcode
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal
);

    statetype state, next_state;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output and next_state gets a default before the case so
        // no path leaves a variable unassigned, which would infer a latch.
        next_state = state;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;

        unique case (state)
            FETCH: begin
                // PC+4 is computed every cycle, but only committed together
                // with the instruction word once memory delivers it.
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                // OldPC + imm: speculative branch target parked in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                unique case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECUTER;
                    OP_ITYPE:          next_state = EXECUTEI;
                    OP_BRANCH:         next_state = BEQ;
                    OP_JAL:            next_state = JAL;
                    default:           next_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                next_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                // The strobe is held through the stall; the store retires on
                // the cycle memory accepts it.
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) next_state = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_SUB;
                Branch     = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC <- ALUOut (target from DECODE) while OldPC+4 is formed
                // for the link write in ALUWB.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCUpdate   = 1'b1;
                next_state = ALUWB;
            end
            ILLEGAL: begin
                // PC was already advanced in FETCH, so the instruction is skipped.
                illegal    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm. Each cycle a test drives reset/mem_ready/op,
// pushes the output vector expected for the state the FSM should be in, and
// pops/compares it against the DUT outputs on the falling edge.
module tb_main_fsm;

    typedef enum int {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } tb_state_e;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [6:0] op;
        tb_state_e  st;
    } step_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] BRQ  = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic       instr_done, illegal;

    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t sb[$];
    outs_t got, expv;

    main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .PCUpdate   (PCUpdate),
        .Branch     (Branch),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign got = '{PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal};

    // Reference output table for each state.
    function automatic outs_t exp_out(input tb_state_e s, input logic mr);
        outs_t o = '0;
        case (s)
            S_FETCH:    begin o.alu_src_b = 2'b10; o.result_src = 2'b10;
                              o.ir_write = mr; o.pc_update = mr; end
            S_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
            S_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            S_MEMREAD:  begin o.adr_src = 1'b1; end
            S_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; o.instr_done = 1'b1; end
            S_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; o.instr_done = mr; end
            S_EXECUTER: begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
            S_EXECUTEI: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
            S_ALUWB:    begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
            S_BEQ:      begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.branch = 1'b1;
                              o.instr_done = 1'b1; end
            S_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_update = 1'b1; end
            S_ILLEGAL:  begin o.illegal = 1'b1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    // Apply one cycle of inputs, record the expectation, move to the sample point.
    task automatic drive(input step_t s);
        reset     = s.rst;
        mem_ready = s.mr;
        op        = s.op;
        sb.push_back(exp_out(s.st, s.mr));
        @(negedge clk);
    endtask

    task automatic test_reset();
        step_t s[3] = '{
            '{1'b1, 1'b0, BAD, S_FETCH},
            '{1'b1, 1'b1, BAD, S_FETCH},
            '{1'b1, 1'b1, LW,  S_FETCH}
        };
        reset = 1'b1; mem_ready = 1'b0; op = BAD;
        @(posedge clk); #1;
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        step_t s[5] = '{
            '{1'b0, 1'b1, LW, S_FETCH},   '{1'b0, 1'b1, LW, S_DECODE},
            '{1'b0, 1'b1, LW, S_MEMADR},  '{1'b0, 1'b1, LW, S_MEMREAD},
            '{1'b0, 1'b1, LW, S_MEMWB}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        step_t s[8] = '{
            '{1'b0, 1'b1, SW, S_FETCH},    '{1'b0, 1'b1, SW, S_DECODE},
            '{1'b0, 1'b1, SW, S_MEMADR},   '{1'b0, 1'b0, SW, S_MEMWRITE},
            '{1'b0, 1'b0, SW, S_MEMWRITE}, '{1'b0, 1'b0, SW, S_MEMWRITE},
            '{1'b0, 1'b1, SW, S_MEMWRITE}, '{1'b0, 1'b0, SW, S_FETCH}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL sw_stall cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    // Fetch stall followed by an R-type instruction.
    task automatic test_fetch_stall_add();
        step_t s[6] = '{
            '{1'b0, 1'b0, RTY, S_FETCH},   '{1'b0, 1'b0, RTY, S_FETCH},
            '{1'b0, 1'b1, RTY, S_FETCH},   '{1'b0, 1'b1, RTY, S_DECODE},
            '{1'b0, 1'b1, RTY, S_EXECUTER},'{1'b0, 1'b1, RTY, S_ALUWB}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL fetch_stall_add cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[4] = '{
            '{1'b0, 1'b1, BAD, S_FETCH},   '{1'b0, 1'b1, BAD, S_DECODE},
            '{1'b0, 1'b1, BAD, S_ILLEGAL}, '{1'b0, 1'b0, BAD, S_FETCH}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset during a MEMREAD stall abandons the load; an I-type follows.
    task automatic test_reset_mid_stall();
        step_t s[10] = '{
            '{1'b0, 1'b1, LW,  S_FETCH},   '{1'b0, 1'b1, LW,  S_DECODE},
            '{1'b0, 1'b1, LW,  S_MEMADR},  '{1'b0, 1'b0, LW,  S_MEMREAD},
            '{1'b1, 1'b0, LW,  S_MEMREAD}, '{1'b0, 1'b0, ITY, S_FETCH},
            '{1'b0, 1'b1, ITY, S_FETCH},   '{1'b0, 1'b1, ITY, S_DECODE},
            '{1'b0, 1'b1, ITY, S_EXECUTEI},'{1'b0, 1'b1, ITY, S_ALUWB}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL reset_mid_stall cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    // jal, beq, sw issued without gaps.
    task automatic test_back_to_back();
        step_t s[12] = '{
            '{1'b0, 1'b1, JL,  S_FETCH},  '{1'b0, 1'b1, JL,  S_DECODE},
            '{1'b0, 1'b1, JL,  S_JAL},    '{1'b0, 1'b1, JL,  S_ALUWB},
            '{1'b0, 1'b1, BRQ, S_FETCH},  '{1'b0, 1'b1, BRQ, S_DECODE},
            '{1'b0, 1'b1, BRQ, S_BEQ},    '{1'b0, 1'b1, SW,  S_FETCH},
            '{1'b0, 1'b1, SW,  S_DECODE}, '{1'b0, 1'b1, SW,  S_MEMADR},
            '{1'b0, 1'b1, SW,  S_MEMWRITE},'{1'b0, 1'b1, SW, S_FETCH}
        };
        foreach (s[i]) begin
            drive(s[i]);
            expv = sb.pop_front();
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, got, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall_add();
        test_illegal();
        test_reset_mid_stall();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
